systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Consumer end of the systolic processor's flat result bus `o_c_full`.
- On a completion pulse it snapshots the SIZE×SIZE result matrix into a shadow bank.
- It then streams the active DIM×DIM sub-matrix out one element per transfer, row-major, over a valid/ready handshake.
- Sits between `systolic_processorVCounter` and the downstream host/UART/FIFO path, and replaces bench-side parallel XOR checking.

Parameters:
- SIZE, 32, physical array dimension (elements per row/column).
- O_BITS, 16, width of one result element in the flat bus.
- DIM_BITS, $clog2(SIZE)+1, width of the active-dimension input.

Ports:
- i_clock  input  1  single clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_c_full  input  SIZE*SIZE*O_BITS  flat result matrix; element k = row*SIZE+col occupies bits [O_BITS*k +: O_BITS].
- i_done  input  1  one-cycle pulse; i_c_full is valid this cycle.
- i_dim  input  DIM_BITS  active matrix dimension, sampled with i_done.
- i_ready  input  1  downstream can accept.
- o_data  output  O_BITS  current element.
- o_valid  output  1  o_data/o_row/o_col/o_last valid.
- o_row  output  DIM_BITS-1  row index of o_data.
- o_col  output  DIM_BITS-1  column index of o_data.
- o_last  output  1  high with the final element (DIM-1, DIM-1).
- o_busy  output  1  high in STREAM.
- o_overrun  output  1  sticky; a completion pulse was dropped.

Behaviour:
- Reset (i_reset=1 at a rising edge):
  - state=IDLE.
  - o_valid, o_last, o_busy, o_overrun all 0.
  - o_data, o_row, o_col all 0.
  - Shadow bank content is don't-care.
  - Reset mid-STREAM aborts the stream immediately; no further beats are issued.
- Dimension latch: dim_q = i_dim when 1 ≤ i_dim ≤ SIZE; otherwise (0 or >SIZE) dim_q = SIZE.
- IDLE:
  - o_valid=0.
  - On i_done: copy i_c_full to the shadow bank, latch dim_q, set row=col=0, go to STREAM.
- STREAM:
  - o_valid=1, o_busy=1.
  - o_data = shadow[row*SIZE+col]; all outputs are registered.
- Latency: i_done at edge t gives o_valid=1 with element (0,0) from edge t+1.
- Handshake:
  - A transfer occurs on an edge where o_valid && i_ready.
  - While o_valid && !i_ready, o_data/o_row/o_col/o_last hold stable.
  - Back-to-back transfers sustain 1 element per clock.
- Index advance on transfer:
  - col+1; when col == dim_q-1, col wraps to 0 and row+1.
  - o_last = (row == dim_q-1) && (col == dim_q-1).
- Stream end:
  - A transfer with o_last=1 returns to IDLE; o_valid=0 next cycle.
  - Exception: a simultaneous i_done re-captures, reloads row=col=0, and stays in STREAM with no bubble and no overrun.
- i_done in STREAM other than on the final-transfer edge:
  - The pulse is ignored and the snapshot is unchanged.
  - o_overrun is set to 1 and stays set until reset.
- Source independence: i_c_full changes after capture have no effect on the stream.
- Transfer count per capture = dim_q².
- Element value is passed through unmodified: bits [O_BITS*k +: O_BITS], no sign handling.
- FSM states are IDLE and STREAM only; there is no illegal-state recovery requirement beyond reset.

Test Plan:
- Basic stream, with SIZE=4, O_BITS=16:
  - Stimulus: element k=16'h0100+k, i_dim=4, i_done pulse, i_ready=1.
  - Response: 16 beats, values 0x0100..0x010F in row-major order, o_last only on beat 16 (row=3, col=3), o_valid low the next cycle.
- Sub-dimension with clamp:
  - Stimulus: i_dim=2.
  - Response: 4 beats 0x0100, 0x0101, 0x0104, 0x0105, with o_last on (1,1).
  - Stimulus: i_dim=0 and, separately, i_dim=7.
  - Response: 16 beats each.
- Backpressure:
  - Stimulus: i_ready toggled 1,0,0,1,… during the stream.
  - Response: o_data/o_row/o_col stable during low cycles, no element dropped or duplicated, total of 16 beats.
- Snapshot and overrun:
  - Stimulus: change i_c_full to all 16'hFFFF after capture, then pulse i_done at beat 5.
  - Response: the original values are still streamed, o_overrun=1 and it remains 1 after stream end until i_reset.
- Chained capture:
  - Stimulus: i_done on the same edge as the o_last transfer, with new data 16'h0200+k.
  - Response: the next cycle shows o_valid=1 with 0x0200 at (0,0), o_overrun=0.
- Reset mid-stream:
  - Stimulus: i_reset=1 at beat 7.
  - Response: the next edge shows o_valid=o_busy=o_last=o_overrun=0.
  - Stimulus: a new i_done afterwards.
  - Response: the stream restarts at (0,0).

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Result stream interface between the drain and its downstream consumer.
// Signals:
//   o_data   element value         (drain -> sink)
//   o_valid  o_data/o_row/o_col/o_last are valid
//   o_row    row index of o_data
//   o_col    column index of o_data
//   o_last   final element of the active sub-matrix
//   i_ready  sink can accept       (sink -> drain)
interface systolic_result_drain_if #(
  parameter int unsigned O_BITS   = 16,
  parameter int unsigned DIM_BITS = 6
);
  logic [O_BITS-1:0]   o_data;
  logic                o_valid;
  logic [DIM_BITS-2:0] o_row;
  logic [DIM_BITS-2:0] o_col;
  logic                o_last;
  logic                i_ready;

  modport master (
    output o_data,
    output o_valid,
    output o_row,
    output o_col,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_row,
    input  o_col,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Consumer end of the systolic processor's flat result bus. A completion pulse snapshots the
// SIZE x SIZE result matrix into a shadow bank; the active DIM x DIM sub-matrix is then streamed
// out one element per transfer, row-major, over a valid/ready handshake.
// Ports:
//   i_clock    clock, rising edge
//   i_reset    synchronous active-high reset
//   i_c_full   flat result matrix, element k = row*SIZE+col at [O_BITS*k +: O_BITS]
//   i_done     one-cycle completion pulse, i_c_full/i_dim valid this cycle
//   i_dim      active dimension; 0 or >SIZE selects SIZE
//   strm       result stream (master side)
//   o_busy     streaming in progress
//   o_overrun  sticky: a completion pulse arrived mid-stream and was dropped
module systolic_result_drain #(
  parameter int unsigned SIZE     = 32,
  parameter int unsigned O_BITS   = 16,
  parameter int unsigned DIM_BITS = $clog2(SIZE) + 1
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [SIZE*SIZE*O_BITS-1:0] i_c_full,
  input  logic                        i_done,
  input  logic [DIM_BITS-1:0]         i_dim,
  systolic_result_drain_if.master     strm,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int unsigned Num = SIZE * SIZE;
  localparam int unsigned Iw  = $clog2(Num);
  localparam int unsigned Rw  = DIM_BITS - 1;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e              state_q, state_d;
  logic [O_BITS-1:0]   shadow_q [Num];
  logic                capture;
  logic                xfer;
  logic [DIM_BITS-1:0] dim_q, dim_d, dim_sel;
  logic [Rw-1:0]       row_q, row_d, col_q, col_d;
  logic [Rw-1:0]       row_nx, col_nx;
  logic [Iw-1:0]       idx_nx;
  logic [O_BITS-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                overrun_q, overrun_d;

  // Out-of-range dimensions fall back to the full physical array.
  always_comb begin
    dim_sel = DIM_BITS'(SIZE);
    if ((i_dim != '0) && (i_dim <= DIM_BITS'(SIZE))) begin
      dim_sel = i_dim;
    end
  end

  // Row-major successor of the current element.
  always_comb begin
    col_nx = col_q + 1'b1;
    row_nx = row_q;
    if ({1'b0, col_q} == (dim_q - 1'b1)) begin
      col_nx = '0;
      row_nx = row_q + 1'b1;
    end
    idx_nx = Iw'(row_nx) * Iw'(SIZE) + Iw'(col_nx);
  end

  always_comb begin
    state_d   = state_q;
    dim_d     = dim_q;
    row_d     = row_q;
    col_d     = col_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    xfer      = (state_q == StStream) && strm.i_ready;

    case (state_q)
      StIdle: begin
        if (i_done) capture = 1'b1;
      end
      StStream: begin
        if (xfer && last_q) begin
          // A pulse coinciding with the final transfer chains straight into the next stream.
          if (i_done) begin
            capture = 1'b1;
          end else begin
            state_d = StIdle;
            last_d  = 1'b0;
          end
        end else begin
          if (i_done) overrun_d = 1'b1;
          if (xfer) begin
            row_d  = row_nx;
            col_d  = col_nx;
            data_d = shadow_q[idx_nx];
            last_d = ({1'b0, row_nx} == (dim_q - 1'b1)) && ({1'b0, col_nx} == (dim_q - 1'b1));
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Element (0,0) comes straight from the bus so it is on the output the cycle after capture.
    if (capture) begin
      state_d = StStream;
      dim_d   = dim_sel;
      row_d   = '0;
      col_d   = '0;
      data_d  = i_c_full[O_BITS-1:0];
      last_d  = (dim_sel == DIM_BITS'(1));
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      dim_q     <= DIM_BITS'(SIZE);
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dim_q     <= dim_d;
      row_q     <= row_d;
      col_q     <= col_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  // Shadow bank needs no reset; it is only read after a capture.
  always_ff @(posedge i_clock) begin
    if (capture) begin
      for (int k = 0; k < Num; k++) begin
        shadow_q[k] <= i_c_full[O_BITS*k +: O_BITS];
      end
    end
  end

  assign strm.o_valid = (state_q == StStream);
  assign strm.o_data  = data_q;
  assign strm.o_row   = row_q;
  assign strm.o_col   = col_q;
  assign strm.o_last  = last_q;
  assign o_busy       = (state_q == StStream);
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

  localparam int unsigned SIZE     = 4;
  localparam int unsigned O_BITS   = 16;
  localparam int unsigned DIM_BITS = 3;

  logic                        clk;
  logic                        rst;
  logic [SIZE*SIZE*O_BITS-1:0] c_full;
  logic                        done;
  logic [DIM_BITS-1:0]         dim;
  logic                        busy;
  logic                        overrun;

  systolic_result_drain_if #(.O_BITS(O_BITS), .DIM_BITS(DIM_BITS)) sif ();

  systolic_result_drain #(.SIZE(SIZE), .O_BITS(O_BITS), .DIM_BITS(DIM_BITS)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_c_full  (c_full),
    .i_done    (done),
    .i_dim     (dim),
    .strm      (sif),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } beat_t;

  typedef struct {
    int          dim_in;
    logic [15:0] base;
    int          mode;       // 0: ready always high, 1: ready pattern 1,0,0,1
    int          exp_beats;
  } vec_t;

  beat_t q[$];
  int    checks   = 0;
  int    failures = 0;
  int    beats    = 0;

  // Monitor state for hold-stability checking.
  logic        hold;
  logic [15:0] h_data;
  logic [1:0]  h_row, h_col;
  logic        h_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mat(input logic [15:0] base);
    for (int k = 0; k < 16; k++) c_full[16*k +: 16] = base + 16'(k);
  endtask

  task automatic push_exp(input int dim_in, input logic [15:0] base);
    int ed;
    beat_t b;
    ed = (dim_in == 0 || dim_in > 4) ? 4 : dim_in;
    for (int r = 0; r < ed; r++) begin
      for (int c = 0; c < ed; c++) begin
        b.data = base + 16'(r * 4 + c);
        b.row  = 2'(r);
        b.col  = 2'(c);
        b.last = (r == ed - 1) && (c == ed - 1);
        q.push_back(b);
      end
    end
  endtask

  // Pulse i_done with a fresh matrix; valid must be up right after the capture edge.
  task automatic start(input int dim_in, input logic [15:0] base);
    set_mat(base);
    dim  = 3'(dim_in);
    done = 1'b1;
    push_exp(dim_in, base);
    beats = 0;
    cycle();
    done = 1'b0;
    chk("start_valid", 32'(sif.o_valid), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_stream(input int mode);
    bit ended = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 300; i++) begin
      sif.i_ready = (mode == 0) ? 1'b1 : pat[i % 4];
      cycle();
      if (!sif.o_valid) begin
        ended = 1'b1;
        break;
      end
    end
    sif.i_ready = 1'b1;
    chk("stream_end_timeout", 32'(ended), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (beats == n) begin
        hit = 1'b1;
        break;
      end
      cycle();
    end
    chk("wait_beats_timeout", 32'(hit), 32'd1);
  endtask

  // Scoreboard: every transfer is popped and compared against the model.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold && sif.o_valid) begin
        chk("hold_data", 32'(sif.o_data), 32'(h_data));
        chk("hold_row", 32'(sif.o_row), 32'(h_row));
        chk("hold_col", 32'(sif.o_col), 32'(h_col));
        chk("hold_last", 32'(sif.o_last), 32'(h_last));
      end
      if (sif.o_valid === 1'b1 && sif.i_ready === 1'b1) begin
        beat_t e;
        beats++;
        chk("beat_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("beat_data", 32'(sif.o_data), 32'(e.data));
          chk("beat_row", 32'(sif.o_row), 32'(e.row));
          chk("beat_col", 32'(sif.o_col), 32'(e.col));
          chk("beat_last", 32'(sif.o_last), 32'(e.last));
        end
      end
      hold   = (sif.o_valid === 1'b1) && (sif.i_ready === 1'b0);
      h_data = sif.o_data;
      h_row  = sif.o_row;
      h_col  = sif.o_col;
      h_last = sif.o_last;
    end
  end

  vec_t vecs [7];

  initial begin
    vecs[0] = '{4, 16'h0100, 0, 16};
    vecs[1] = '{2, 16'h0100, 0, 4};
    vecs[2] = '{0, 16'h0100, 0, 16};
    vecs[3] = '{7, 16'h0100, 0, 16};
    vecs[4] = '{1, 16'h0150, 0, 1};
    vecs[5] = '{3, 16'h0180, 0, 9};
    vecs[6] = '{4, 16'h0100, 1, 16};

    rst         = 1'b1;
    done        = 1'b0;
    dim         = '0;
    c_full      = '0;
    sif.i_ready = 1'b1;
    hold        = 1'b0;
    repeat (3) cycle();
    chk("rst_valid", 32'(sif.o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(sif.o_last), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(sif.o_data), 32'd0);
    chk("rst_row", 32'(sif.o_row), 32'd0);
    chk("rst_col", 32'(sif.o_col), 32'd0);
    rst = 1'b0;
    cycle();

    for (int v = 0; v < 7; v++) begin
      sif.i_ready = 1'b1;
      start(vecs[v].dim_in, vecs[v].base);
      finish_stream(vecs[v].mode);
      chk($sformatf("vec%0d_beats", v), 32'(beats), 32'(vecs[v].exp_beats));
      chk($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
      cycle();
    end

    // Chained capture on the final-transfer edge.
    start(2, 16'h0100);
    wait_beats(3);
    chk("chain_last_presented", 32'(sif.o_last), 32'd1);
    set_mat(16'h0200);
    dim  = 3'd4;
    done = 1'b1;
    push_exp(4, 16'h0200);
    cycle();
    done = 1'b0;
    chk("chain_valid", 32'(sif.o_valid), 32'd1);
    chk("chain_data", 32'(sif.o_data), 32'h0200);
    chk("chain_row", 32'(sif.o_row), 32'd0);
    chk("chain_col", 32'(sif.o_col), 32'd0);
    chk("chain_overrun", 32'(overrun), 32'd0);
    finish_stream(0);
    chk("chain_beats", 32'(beats), 32'd20);
    cycle();

    // Snapshot isolation and sticky overrun.
    start(4, 16'h0300);
    for (int k = 0; k < 16; k++) c_full[16*k +: 16] = 16'hFFFF;
    wait_beats(4);
    done = 1'b1;
    cycle();
    done = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    finish_stream(0);
    chk("overrun_beats", 32'(beats), 32'd16);
    repeat (3) cycle();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while beat 7 is presented.
    start(4, 16'h0400);
    wait_beats(6);
    rst = 1'b1;
    cycle();
    chk("midrst_valid", 32'(sif.o_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_last", 32'(sif.o_last), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    q.delete();
    cycle();
    chk("midrst_idle", 32'(sif.o_valid), 32'd0);
    start(4, 16'h0500);
    chk("restart_data", 32'(sif.o_data), 32'h0500);
    chk("restart_row", 32'(sif.o_row), 32'd0);
    chk("restart_col", 32'(sif.o_col), 32'd0);
    finish_stream(0);
    chk("restart_beats", 32'(beats), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
